// File: rtl/reg_bank_reader.sv
// reg_bank_reader: takes an atomic snapshot of q0..q2 on start and streams
// it out as one byte-wide beat per valid/ready handshake, with a last marker,
// a one-cycle done pulse and a wrapping completed-frame counter.
// Optional build macro READBACK_CHECKSUM_EN appends a fourth beat carrying
// snap0^snap1^snap2; last then moves to that beat.
module reg_bank_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

`ifdef READBACK_CHECKSUM_EN
    localparam int unsigned ST_W = 3;
`else
    localparam int unsigned ST_W = 2;
`endif

    localparam logic [ST_W-1:0] IDLE = ST_W'(0);
    localparam logic [ST_W-1:0] S0   = ST_W'(1);
    localparam logic [ST_W-1:0] S1   = ST_W'(2);
    localparam logic [ST_W-1:0] S2   = ST_W'(3);
`ifdef READBACK_CHECKSUM_EN
    localparam logic [ST_W-1:0] SC   = ST_W'(4);
`endif

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] snap0_q, snap0_d;
    logic [WIDTH-1:0] snap1_q, snap1_d;
    logic [WIDTH-1:0] snap2_q, snap2_d;
    logic [WIDTH-1:0] data_d;
    logic             valid_d;
    logic             last_d;
    logic             busy_d;
    logic             done_d;
    logic [CNT_W-1:0] cnt_d;
    logic             xfer;

    assign xfer = out_valid && out_ready;

    // State, snapshot and registered outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap0_q   <= '0;
            snap1_q   <= '0;
            snap2_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            snap0_q   <= snap0_d;
            snap1_q   <= snap1_d;
            snap2_q   <= snap2_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            busy      <= busy_d;
            done      <= done_d;
            frame_cnt <= cnt_d;
        end
    end

    // Next-state and next-output logic; beats only advance on a handshake
    always_comb begin
        state_d = state_q;
        snap0_d = snap0_q;
        snap1_d = snap1_q;
        snap2_d = snap2_q;
        data_d  = out_data;
        valid_d = out_valid;
        last_d  = out_last;
        done_d  = 1'b0;
        cnt_d   = frame_cnt;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap0_d = q0;
                    snap1_d = q1;
                    snap2_d = q2;
                    state_d = S0;
                    valid_d = 1'b1;
                    data_d  = q0;
                    last_d  = 1'b0;
                end
            end
            S0: begin
                if (xfer) begin
                    state_d = S1;
                    data_d  = snap1_q;
                end
            end
            S1: begin
                if (xfer) begin
                    state_d = S2;
                    data_d  = snap2_q;
`ifdef READBACK_CHECKSUM_EN
                    last_d  = 1'b0;
`else
                    last_d  = 1'b1;
`endif
                end
            end
            S2: begin
                if (xfer) begin
`ifdef READBACK_CHECKSUM_EN
                    state_d = SC;
                    data_d  = snap0_q ^ snap1_q ^ snap2_q;
                    last_d  = 1'b1;
`else
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = frame_cnt + CNT_W'(1);
`endif
                end
            end
`ifdef READBACK_CHECKSUM_EN
            SC: begin
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = frame_cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                data_d  = '0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Scoreboard bench for reg_bank_reader: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_reg_bank_reader;

`ifdef READBACK_CHECKSUM_EN
    localparam int NUM_BEATS = 4;
`else
    localparam int NUM_BEATS = 3;
`endif
    localparam int CNT_MOD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] q0 = 8'h00;
    logic [7:0] q1 = 8'h00;
    logic [7:0] q2 = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [1:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    int xfer_count = 0;
    int model_cnt = 0;

    logic       prev_rst = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    logic       prev_final = 1'b0;

    always #5 clk = ~clk;

    reg_bank_reader #(.WIDTH(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .q0(q0), .q1(q1), .q2(q2),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .frame_cnt(frame_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b0, b});
`ifdef READBACK_CHECKSUM_EN
        exp_q.push_back({1'b0, c});
        exp_q.push_back({1'b1, a ^ b ^ c});
`else
        exp_q.push_back({1'b1, c});
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cyc++;
            if (done) return;
        end
        check("done_timeout", 0, 1);
    endtask

    // Monitor: reset values, handshake scoreboard, hold-under-stall, done/counter model
    always @(negedge clk) begin
        if (!prev_rst) begin
            check("rst_valid", int'(out_valid), 0);
            check("rst_data", int'(out_data), 0);
            check("rst_done", int'(done), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_cnt", int'(frame_cnt), 0);
            model_cnt = 0;
        end else begin
            check("done_pulse", int'(done), int'(prev_final));
            if (prev_final) begin
                model_cnt = (model_cnt + 1) % CNT_MOD;
                check("frame_cnt", int'(frame_cnt), model_cnt);
            end
            if (prev_valid && !prev_ready) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'(out_data), int'(prev_data));
                check("stall_last", int'(out_last), int'(prev_last));
            end
            if (!out_valid) check("idle_data_zero", int'(out_data), 0);
            check("busy_vs_valid", int'(busy), int'(out_valid));
        end
        if (rst_n && out_valid && out_ready) begin
            xfer_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", int'({out_last, out_data}), -1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("beat_data", int'(out_data), int'(e[7:0]));
                check("beat_last", int'(out_last), int'(e[8]));
            end
        end
        prev_final = rst_n && out_valid && out_ready && out_last;
        prev_valid = rst_n && out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_rst   = rst_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int wrap_exp[5];
        wrap_exp[0] = 1; wrap_exp[1] = 2; wrap_exp[2] = 3; wrap_exp[3] = 0; wrap_exp[4] = 1;

        // Reset with start and toggling inputs
        rst_n = 1'b0;
        start = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1 q0 = ~q0; q1 = q1 + 8'd3; q2 = q2 ^ 8'h5A;
        end
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_cnt", int'(frame_cnt), 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-frame after the first beat
        q0 = 8'h11; q1 = 8'h22; q2 = 8'h33;
        out_ready = 1'b1;
        push_frame(8'h11, 8'h22, 8'h33);
        base = xfer_count;
        pulse_start();
        check("mid_first_valid", int'(out_valid), 1);
        check("mid_first_data", int'(out_data), 8'h11);
        @(posedge clk);
        #1;
        check("mid_one_xfer", xfer_count - base, 1);
        check("mid_second_data", int'(out_data), 8'h22);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("mid_abort_valid", int'(out_valid), 0);
        check("mid_abort_done", int'(done), 0);
        check("mid_abort_cnt", int'(frame_cnt), 0);
        push_frame(8'h11, 8'h22, 8'h33);
        pulse_start();
        wait_done(cyc);
        check("mid_refill_cnt", int'(frame_cnt), 1);
        check("mid_refill_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Basic frame, ready held high
        q0 = 8'h01; q1 = 8'h0F; q2 = 8'hF0;
        push_frame(8'h01, 8'h0F, 8'hF0);
        pulse_start();
        check("basic_latency_valid", int'(out_valid), 1);
        check("basic_first_data", int'(out_data), 8'h01);
        wait_done(cyc);
        check("basic_start_to_done", cyc, NUM_BEATS + 1);
        check("basic_cnt", int'(frame_cnt), 2);
        check("basic_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Backpressure and snapshot atomicity
        out_ready = 1'b0;
        q0 = 8'h01; q1 = 8'hFF; q2 = 8'hF0;
        push_frame(8'h01, 8'hFF, 8'hF0);
        base = xfer_count;
        pulse_start();
        q1 = 8'hAA;
        for (int b = 0; b < NUM_BEATS; b++) begin
            repeat (5) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        check("bp_done", int'(done), 1);
        check("bp_xfers", xfer_count - base, NUM_BEATS);
        check("bp_cnt", int'(frame_cnt), 3);
        @(posedge clk);
        #1;
        check("bp_done_one_cycle", int'(done), 0);

        // Start held for the whole frame: exactly one frame
        out_ready = 1'b1;
        q0 = 8'h5A; q1 = 8'hA5; q2 = 8'h3C;
        push_frame(8'h5A, 8'hA5, 8'h3C);
        base = xfer_count;
        start = 1'b1;
        repeat (NUM_BEATS + 1) @(posedge clk);
        #1 start = 1'b0;
        check("busy_start_done", int'(done), 1);
        check("busy_start_cnt", int'(frame_cnt), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("busy_start_idle", int'(out_valid), 0);
        check("busy_start_xfers", xfer_count - base, NUM_BEATS);

        // Restart taken in the done cycle
        q0 = 8'hC0; q1 = 8'hC1; q2 = 8'hC2;
        push_frame(8'hC0, 8'hC1, 8'hC2);
        pulse_start();
        wait_done(cyc);
        q0 = 8'hD0; q1 = 8'hD1; q2 = 8'hD2;
        push_frame(8'hD0, 8'hD1, 8'hD2);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("restart_valid", int'(out_valid), 1);
        check("restart_data", int'(out_data), 8'hD0);
        check("restart_cnt", int'(frame_cnt), 1);
        wait_done(cyc);
        check("restart_cnt2", int'(frame_cnt), 2);
        check("restart_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Counter wrap with a 2-bit counter
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            q0 = 8'(i); q1 = 8'(i * 16); q2 = 8'(8'h80 + i);
            push_frame(8'(i), 8'(i * 16), 8'(8'h80 + i));
            pulse_start();
            wait_done(cyc);
            check("wrap_cnt", int'(frame_cnt), wrap_exp[i]);
            @(posedge clk);
            #1;
        end
        check("wrap_drained", exp_q.size(), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
- Read-side companion to the enabled register bank. Takes an atomic snapshot of the bank's three outputs (q0, q1, q2) on a start request.
- Streams the snapshot out as a sequence of bytes over a valid/ready interface, one byte per accepted beat, with a last marker.
- Sits between the register bank and a debug/readback path, so software or a bench can read a consistent view of all registers without stalling the writer.

Parameters:
- WIDTH, 8, bit width of each register and of the output data beat.
- CNT_W, 8, width of the completed-frame counter (wraps modulo 2^CNT_W).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a snapshot and readout; sampled only in IDLE.
- q0  input  WIDTH  register 0 value from the bank.
- q1  input  WIDTH  register 1 value from the bank.
- q2  input  WIDTH  register 2 value from the bank.
- out_ready  input  1  downstream can accept a beat.
- out_valid  output  1  out_data holds a valid beat.
- out_data  output  WIDTH  current beat.
- out_last  output  1  current beat is the final beat of the frame.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse after the final beat handshake.
- frame_cnt  output  CNT_W  number of completed frames.

Behaviour:
- Reset (rst_n low at a rising edge, synchronous only): state=IDLE. Snapshot registers, out_data, out_valid, out_last, busy, done and frame_cnt all clear to 0. Reset overrides every other input. Reset mid-frame aborts the frame with no done pulse and no frame_cnt increment.
- States: IDLE, S0, S1, S2 (plus SC with the optional feature).
- IDLE to S0: at a rising edge with start=1, snap0..2 <= q0..q2 in that same edge. From the next cycle out_valid=1 and out_data=snap0. Latency is one cycle from start to the first valid beat.
- Handshake: a beat transfers on a rising edge where out_valid && out_ready.
  - Without a transfer: out_data, out_valid and out_last hold unchanged.
  - out_valid never drops without a transfer.
  - out_valid does not depend combinationally on out_ready.
- Beat transitions on transfer: S0 to S1 (out_data=snap1); S1 to S2 (out_data=snap2, out_last=1); S2 to IDLE.
- Final transfer: out_valid=0, out_last=0, done=1 for exactly one cycle, frame_cnt += 1 (wraps from 2^CNT_W-1 to 0).
- With out_ready held high, a frame takes 3 beat cycles and start-to-done spans 4 cycles.
- start while busy is ignored and not queued.
- Earliest restart is the cycle in which done is high. A start sampled that cycle is accepted and the next frame begins with no bubble beyond that cycle.
- Changes on q0..q2 after the snapshot edge do not affect the in-flight frame, so the snapshot is atomic.
- out_data is 0 whenever out_valid=0.

Optional Feature:
- Macro: READBACK_CHECKSUM_EN.
- Defined:
  - An extra state SC follows S2. Transfer in S2 moves to SC with out_data=snap0^snap1^snap2 (bitwise XOR).
  - out_last moves to the SC beat, so S2 no longer asserts out_last.
  - done and the frame_cnt increment occur after the SC transfer. A frame is 4 beats.
- Undefined: 3-beat frame exactly as above. No SC state or XOR logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 and q0..q2 toggling -> out_valid=0, busy=0, done=0, frame_cnt=0, out_data=0.
- Basic frame: q0=8'h01, q1=8'h0F, q2=8'hF0, out_ready=1, pulse start -> beats 01, 0F, F0 on consecutive cycles; out_last only on F0; done one cycle later; frame_cnt=1. With READBACK_CHECKSUM_EN, a 4th beat FE carries last.
- Backpressure and atomicity: start with q1=8'hFF, then change q1 to 8'hAA. Hold out_ready=0 for 5 cycles on each beat -> data stays 01/FF/F0 and stable throughout; out_valid never drops; exactly 3 transfers.
- Start while busy: assert start on every cycle of a frame -> exactly one frame is emitted. A restart taken in the done cycle produces the second frame's first beat on the next cycle; frame_cnt increments once per frame.
- Reset mid-frame: drop rst_n after the first beat transfers -> next cycle IDLE, out_valid=0, no done, frame_cnt unchanged. A following start emits a full frame from beat 0.
- Counter wrap: with CNT_W=2, run 5 frames -> frame_cnt sequence 1, 2, 3, 0, 1.
